// File: rtl/pb_err_slave.sv
// AXI4 DECERR subordinate: one B beat per write, len+1 R beats of RespData per read.
// Optional error counter output err_cnt_o is enabled by defining PB_ERR_SLAVE_STATS_EN.
module pb_err_slave #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter logic [63:0] RespData  = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
`ifdef PB_ERR_SLAVE_STATS_EN
  output logic [15:0]          err_cnt_o,
`endif
  output logic                 busy_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_SEND} rstate_e;

  wstate_e              r_wstate, w_wstate_nxt;
  rstate_e              r_rstate, w_rstate_nxt;
  logic [IdWidth-1:0]   r_bid;
  logic [IdWidth-1:0]   r_rid;
  logic [7:0]           r_cnt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_last;

  assign aw_ready_o = (r_wstate == W_IDLE);
  assign w_ready_o  = (r_wstate == W_DATA);
  assign b_valid_o  = (r_wstate == W_RESP);
  assign b_id_o     = r_bid;
  assign b_resp_o   = 2'b11;

  assign ar_ready_o = (r_rstate == R_IDLE);
  assign r_valid_o  = (r_rstate == R_SEND);
  // Gate with state so the cleared counter does not flag last while idle.
  assign w_r_last   = (r_rstate == R_SEND) && (r_cnt == 8'd0);
  assign r_last_o   = w_r_last;
  assign r_id_o     = r_rid;
  assign r_data_o   = DataWidth'(RespData);
  assign r_resp_o   = 2'b11;

  assign busy_o = (r_wstate != W_IDLE) || (r_rstate != R_IDLE);

  assign w_aw_hs = aw_valid_i && aw_ready_o;
  assign w_w_hs  = w_valid_i  && w_ready_o;
  assign w_b_hs  = b_valid_o  && b_ready_i;
  assign w_ar_hs = ar_valid_i && ar_ready_o;
  assign w_r_hs  = r_valid_o  && r_ready_i;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_last_i) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_SEND;
      R_SEND:  if (w_r_hs && w_r_last) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_bid    <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) r_bid <= aw_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_cnt    <= 8'd0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rid <= ar_id_i;
        r_cnt <= ar_len_i;
      end else if (w_r_hs && !w_r_last) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

`ifdef PB_ERR_SLAVE_STATS_EN
  logic [15:0] r_err_cnt;
  logic [16:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_b_hs) + 17'(w_r_hs && w_r_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= 16'd0;
    end else if (w_err_sum[16]) begin
      r_err_cnt <= 16'hFFFF;
    end else begin
      r_err_cnt <= w_err_sum[15:0];
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_pb_err_slave.sv
// Directed bench for pb_err_slave; inputs change and outputs are sampled on the falling edge.
module tb_pb_err_slave;

  localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aw_valid_i = 1'b0, aw_ready_o;
  logic [3:0]  aw_id_i = '0;
  logic        w_valid_i = 1'b0, w_ready_o, w_last_i = 1'b0;
  logic        b_valid_o, b_ready_i = 1'b0;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 1'b0, ar_ready_o;
  logic [3:0]  ar_id_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic        r_valid_o, r_ready_i = 1'b0;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        busy_o;
`ifdef PB_ERR_SLAVE_STATS_EN
  logic [15:0] err_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pb_err_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
`ifdef PB_ERR_SLAVE_STATS_EN
    .err_cnt_o(err_cnt_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    int beats, lasts;
    bit last_pos_ok;

    // Reset and idle
    cyc(); cyc();
    check("rst_aw_ready", aw_ready_o, 1);
    check("rst_busy_in_reset", busy_o, 0);
    rst_ni = 1'b1;
    w_valid_i = 1'b1;
    cyc();
    check("idle_aw_ready", aw_ready_o, 1);
    check("idle_ar_ready", ar_ready_o, 1);
    check("idle_w_ready_no_aw", w_ready_o, 0);
    check("idle_b_valid", b_valid_o, 0);
    check("idle_r_valid", r_valid_o, 0);
    check("idle_r_last", r_last_o, 0);
    check("idle_b_id", b_id_o, 0);
    check("idle_r_id", r_id_o, 0);
    check("idle_busy", busy_o, 0);
    check("b_resp", b_resp_o, 2'b11);
    check("r_resp", r_resp_o, 2'b11);
    check("r_data", r_data_o, EXP_DATA);
    w_valid_i = 1'b0;

    // Write id=5, 3 beats
    aw_valid_i = 1'b1; aw_id_i = 4'd5;
    cyc();
    check("wr_w_ready", w_ready_o, 1);
    check("wr_aw_ready_low", aw_ready_o, 0);
    check("wr_busy", busy_o, 1);
    aw_valid_i = 1'b0; aw_id_i = 4'd0;
    w_valid_i = 1'b1; w_last_i = 1'b0;
    cyc();
    check("wr_beat1_no_b", b_valid_o, 0);
    cyc();
    check("wr_beat2_w_ready", w_ready_o, 1);
    w_last_i = 1'b1;
    cyc();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("wr_b_valid", b_valid_o, 1);
    check("wr_b_id", b_id_o, 5);
    check("wr_w_ready_low", w_ready_o, 0);
    cyc();
    check("wr_b_stall_valid", b_valid_o, 1);
    check("wr_b_stall_id", b_id_o, 5);
    b_ready_i = 1'b1;
    cyc();
    b_ready_i = 1'b0;
    check("wr_b_done", b_valid_o, 0);
    check("wr_busy_fall", busy_o, 0);
    check("wr_aw_ready_back", aw_ready_o, 1);

    // Read id=9 len=3 with toggling r_ready
    ar_valid_i = 1'b1; ar_id_i = 4'd9; ar_len_i = 8'd3;
    cyc();
    ar_valid_i = 1'b0; ar_id_i = 4'd0; ar_len_i = 8'd0;
    check("rd_r_valid", r_valid_o, 1);
    check("rd_ar_ready_low", ar_ready_o, 0);
    beats = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      check("rd_r_valid_hold", r_valid_o, 1);
      check("rd_r_id", r_id_o, 9);
      check("rd_r_data", r_data_o, EXP_DATA);
      check("rd_r_last", r_last_o, (beats == 3));
      r_ready_i = (c % 2 == 1);
      if (r_ready_i) beats++;
      cyc();
    end
    r_ready_i = 1'b0;
    check("rd_beat_count", beats, 4);
    check("rd_done_valid", r_valid_o, 0);
    check("rd_done_ar_ready", ar_ready_o, 1);

    // Simultaneous write and read after a fresh reset
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    aw_valid_i = 1'b1; aw_id_i = 4'd2;
    ar_valid_i = 1'b1; ar_id_i = 4'd7; ar_len_i = 8'd0;
    cyc();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    check("sim_w_ready", w_ready_o, 1);
    check("sim_r_valid", r_valid_o, 1);
    check("sim_r_last", r_last_o, 1);
    check("sim_r_id", r_id_o, 7);
    w_valid_i = 1'b1; w_last_i = 1'b1;
    cyc();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("sim_b_valid", b_valid_o, 1);
    check("sim_b_id", b_id_o, 2);
    check("sim_r_still", r_valid_o, 1);
    b_ready_i = 1'b1; r_ready_i = 1'b1;
    cyc();
    b_ready_i = 1'b0; r_ready_i = 1'b0;
    check("sim_b_done", b_valid_o, 0);
    check("sim_r_done", r_valid_o, 0);
    check("sim_busy", busy_o, 0);
`ifdef PB_ERR_SLAVE_STATS_EN
    check("sim_err_cnt", err_cnt_o, 2);
`endif

    // Read len=255
    ar_valid_i = 1'b1; ar_id_i = 4'd1; ar_len_i = 8'd255;
    cyc();
    ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    beats = 0; lasts = 0; last_pos_ok = 1'b1;
    for (int c = 0; c < 300 && r_valid_o; c++) begin
      if (r_last_o) begin
        lasts++;
        if (beats != 255) last_pos_ok = 1'b0;
      end
      beats++;
      cyc();
    end
    r_ready_i = 1'b0;
    check("long_beats", beats, 256);
    check("long_lasts", lasts, 1);
    check("long_last_pos", last_pos_ok, 1);
    check("long_idle", r_valid_o, 0);

    // Reset during beat 2 of a len=7 read
    ar_valid_i = 1'b1; ar_id_i = 4'd6; ar_len_i = 8'd7;
    cyc();
    ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    cyc(); cyc();
    check("abort_pre_valid", r_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("abort_r_valid", r_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_r_id", r_id_o, 0);
    r_ready_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    ar_valid_i = 1'b1; ar_id_i = 4'd3; ar_len_i = 8'd0;
    cyc();
    ar_valid_i = 1'b0;
    check("post_r_valid", r_valid_o, 1);
    check("post_r_last", r_last_o, 1);
    check("post_r_id", r_id_o, 3);
    r_ready_i = 1'b1;
    cyc();
    r_ready_i = 1'b0;
    check("post_done", r_valid_o, 0);
`ifdef PB_ERR_SLAVE_STATS_EN
    check("post_err_cnt", err_cnt_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
